// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: write-only HD44780-style bus cycle generator.
// Each accepted request produces RS/DB setup, an E pulse, a hold phase and
// then a command-execution wait. busy is reported upstream throughout, and
// system_ready is raised once the power-up delay has elapsed.
// Optional build macro LCD_DROP_CNT_EN enables the saturating drop_cnt
// counter of rejected requests. Without it, drop_cnt is tied to zero.
module lcd_bus_driver #(
    parameter int unsigned PWRUP_CYC     = 750000,
    parameter int unsigned SETUP_CYC     = 3,
    parameter int unsigned EHIGH_CYC     = 25,
    parameter int unsigned HOLD_CYC      = 2,
    parameter int unsigned EXEC_CYC      = 2500,
    parameter int unsigned EXEC_LONG_CYC = 82000
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic [1:0] user_op,
    input  logic       send,
    input  logic [7:0] din,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       busy,
    output logic       system_ready,
    output logic [7:0] drop_cnt
);

    localparam int unsigned MAX_CYC = (PWRUP_CYC > EXEC_LONG_CYC) ? PWRUP_CYC : EXEC_LONG_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] PWRUP_LIM = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LIM = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EHIGH_LIM = CNT_W'(EHIGH_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LIM  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LIM  = CNT_W'(EXEC_LONG_CYC - 1);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_IDLE,
        S_SETUP,
        S_EHIGH,
        S_HOLD,
        S_EXEC
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             long_q;
    logic             accept;
    logic             e_nxt;

    // A request is taken only in IDLE and only for instruction/data ops
    assign accept = (state == S_IDLE) && send && !user_op[1];

    // State, counter and latched bus values
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state        <= S_PWRUP;
            cnt          <= '0;
            lcd_data     <= '0;
            lcd_rs       <= 1'b0;
            lcd_e        <= 1'b0;
            long_q       <= 1'b0;
            system_ready <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lcd_e <= e_nxt;
            if (accept) begin
                lcd_data <= din;
                lcd_rs   <= user_op[0];
                long_q   <= !user_op[0] && (din[7:2] == 6'd0) && (din[1:0] != 2'd0);
            end
            if (state == S_PWRUP && state_nxt == S_IDLE)
                system_ready <= 1'b1;
        end
    end

    // Next state and phase counter; the counter restarts on every phase change
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        case (state)
            S_PWRUP: if (cnt >= PWRUP_LIM) begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
            S_IDLE: begin
                cnt_nxt = '0;
                if (accept)
                    state_nxt = S_SETUP;
            end
            S_SETUP: if (cnt >= SETUP_LIM) begin
                state_nxt = S_EHIGH;
                cnt_nxt   = '0;
            end
            S_EHIGH: if (cnt >= EHIGH_LIM) begin
                state_nxt = S_HOLD;
                cnt_nxt   = '0;
            end
            S_HOLD: if (cnt >= HOLD_LIM) begin
                state_nxt = S_EXEC;
                cnt_nxt   = '0;
            end
            S_EXEC: if (cnt >= (long_q ? LONG_LIM : EXEC_LIM)) begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_PWRUP;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs: E is registered from the next state so the strobe is glitch-free
    always_comb begin
        busy   = (state != S_IDLE);
        lcd_rw = 1'b0;
        e_nxt  = (state_nxt == S_EHIGH);
    end

`ifdef LCD_DROP_CNT_EN
    // Saturating count of requests that arrive while not able to accept them
    always_ff @(posedge CLOCK_50) begin
        if (rst)
            drop_cnt <= '0;
        else if (send && !accept && drop_cnt != '1)
            drop_cnt <= drop_cnt + 1'b1;
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_lcd_bus_driver.sv
// tb_lcd_bus_driver: directed bench for lcd_bus_driver with shortened timing.
module tb_lcd_bus_driver;

    logic       CLOCK_50 = 1'b0;
    logic       rst      = 1'b1;
    logic [1:0] user_op  = 2'b00;
    logic       send     = 1'b0;
    logic [7:0] din      = 8'h00;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_e, busy, system_ready;
    logic [7:0] drop_cnt;

    int unsigned total = 0;
    int unsigned bad   = 0;

`ifdef LCD_DROP_CNT_EN
    localparam int unsigned DROP_INC = 1;
`else
    localparam int unsigned DROP_INC = 0;
`endif

    lcd_bus_driver #(
        .PWRUP_CYC    (100),
        .SETUP_CYC    (3),
        .EHIGH_CYC    (25),
        .HOLD_CYC     (2),
        .EXEC_CYC     (50),
        .EXEC_LONG_CYC(200)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .rst         (rst),
        .user_op     (user_op),
        .send        (send),
        .din         (din),
        .lcd_data    (lcd_data),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_e       (lcd_e),
        .busy        (busy),
        .system_ready(system_ready),
        .drop_cnt    (drop_cnt)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int unsigned cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // E pulse monitor, sampled on the falling edge
    int unsigned e_pulses = 0;
    int unsigned e_rise   = 0;
    int unsigned e_width  = 0;
    int unsigned chg_viol = 0;
    logic        e_prev   = 1'b0;
    logic [7:0]  e_data;
    logic        e_rs;
    always @(negedge CLOCK_50) begin
        if (lcd_e && !e_prev) begin
            e_pulses = e_pulses + 1;
            e_rise   = cyc;
            e_width  = 0;
            e_data   = lcd_data;
            e_rs     = lcd_rs;
        end
        if (lcd_e) begin
            e_width = e_width + 1;
            if (lcd_data != e_data || lcd_rs != e_rs)
                chg_viol = chg_viol + 1;
        end
        e_prev = lcd_e;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Issue a one-cycle send; returns the cycle number of the accept edge
    task automatic send_req(input logic [1:0] op, input logic [7:0] d, output int unsigned acc);
        user_op = op;
        din     = d;
        send    = 1'b1;
        tick();
        acc  = cyc;
        send = 1'b0;
    endtask

    // Count edges after the current point until busy drops (bounded)
    task automatic wait_idle(output int unsigned n);
        n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
    endtask

    int unsigned acc, n, p0, exp_drop;

    initial begin
        exp_drop = 0;
        tick();
        tick();
        check("rst_e", lcd_e, 0);
        check("rst_data", lcd_data, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_busy", busy, 1);
        check("rst_ready", system_ready, 0);
        check("rst_drop", drop_cnt, 0);
        rst = 1'b0;

        // Power-up with a stray send at cycle 50
        repeat (49) tick();
        user_op = 2'b01; din = 8'hAA; send = 1'b1;
        tick();
        send = 1'b0;
        exp_drop += DROP_INC;
        repeat (49) tick();
        check("pwr_ready_99", system_ready, 0);
        check("pwr_busy_99", busy, 1);
        tick();
        check("pwr_ready_100", system_ready, 1);
        check("pwr_busy_100", busy, 0);
        check("pwr_no_e", e_pulses, 0);
        check("pwr_drop", drop_cnt, exp_drop);
        check("rw_low", lcd_rw, 0);

        // Data write
        send_req(2'b01, 8'h41, acc);
        check("dw_rs", lcd_rs, 1);
        check("dw_data", lcd_data, 8'h41);
        check("dw_busy", busy, 1);
        wait_idle(n);
        check("dw_busy_len", n + 1 - 1, 80);
        check("dw_e_delay", e_rise - acc, 3);
        check("dw_e_width", e_width, 25);
        check("dw_pulses", e_pulses, 1);

        // Long command, then an ordinary instruction
        send_req(2'b00, 8'h01, acc);
        check("lc_rs", lcd_rs, 0);
        check("lc_data", lcd_data, 8'h01);
        wait_idle(n);
        check("lc_busy_len", n, 230);
        send_req(2'b00, 8'h80, acc);
        wait_idle(n);
        check("ins_busy_len", n, 80);
        check("ins_data", lcd_data, 8'h80);

        // Busy collision in the middle of EHIGH
        p0 = e_pulses;
        send_req(2'b01, 8'h41, acc);
        repeat (10) tick();
        check("col_e_high", lcd_e, 1);
        user_op = 2'b01; din = 8'h42; send = 1'b1;
        tick();
        send = 1'b0;
        exp_drop += DROP_INC;
        wait_idle(n);
        check("col_busy_len", n + 11, 80);
        check("col_pulses", e_pulses - p0, 1);
        check("col_data", lcd_data, 8'h41);
        check("col_drop", drop_cnt, exp_drop);

        // Reserved op in IDLE
        p0 = e_pulses;
        user_op = 2'b10; din = 8'h99; send = 1'b1;
        tick();
        send = 1'b0;
        exp_drop += DROP_INC;
        check("res_busy", busy, 0);
        repeat (10) tick();
        check("res_busy_later", busy, 0);
        check("res_no_e", e_pulses - p0, 0);
        check("res_data", lcd_data, 8'h41);
        check("res_drop", drop_cnt, exp_drop);

        // Back-to-back: send on the edge busy falls, held one more cycle
        send_req(2'b01, 8'h55, acc);
        repeat (79) tick();
        check("b2b_busy_79", busy, 1);
        user_op = 2'b01; din = 8'h66; send = 1'b1;
        tick();
        exp_drop += DROP_INC;
        check("b2b_busy_fall", busy, 0);
        check("b2b_not_taken", lcd_data, 8'h55);
        tick();
        send = 1'b0;
        check("b2b_taken_busy", busy, 1);
        check("b2b_taken_data", lcd_data, 8'h66);
        wait_idle(n);
        check("b2b_busy_len", n, 80);
        check("b2b_drop", drop_cnt, exp_drop);

        // Reset mid-pulse
        send_req(2'b01, 8'h77, acc);
        repeat (5) tick();
        check("rmp_e_high", lcd_e, 1);
        rst = 1'b1;
        tick();
        check("rmp_e", lcd_e, 0);
        check("rmp_data", lcd_data, 0);
        check("rmp_busy", busy, 1);
        check("rmp_ready", system_ready, 0);
        check("rmp_drop", drop_cnt, 0);
        rst = 1'b0;
        p0 = e_pulses;
        n = 0;
        while (!system_ready && n < 300) begin
            tick();
            n++;
        end
        check("rmp_pwrup_len", n, 100);
        check("rmp_busy_after", busy, 0);
        check("rmp_no_e", e_pulses - p0, 0);
        check("stable_under_e", chg_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
